// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, IR field positions and FSM encoding shared by the hazard/flush controller.
package hazard_pkg;
  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;
  localparam int ADDR_STEP = 2;
  localparam int OPC_LSB = 12;
  localparam int RA_LSB = 9;
  localparam int RB_LSB = 6;
  localparam logic IDLE = 1'b0;
  localparam logic MULTI = 1'b1;
endpackage

// File: rtl/hazard_flush_ctrl_lowest_set_bit.sv
// lowest_set_bit: index of the lowest set bit of an 8-bit mask plus empty/single-bit flags.
module lowest_set_bit (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       none,
  output logic       single
);
  always_comb begin
    idx = '0;
    for (int i = 7; i >= 0; i--) idx = mask[i] ? 3'(i) : idx;
  end
  assign none = ~|mask;
  assign single = ~none & ~|(mask & (mask - 8'd1));
endmodule

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: load-use stall, two-cycle branch flush and LM/SM micro-op sequencing.
module hazard_flush_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir_rr,
  input  logic [15:0] ex_ir,
  input  logic        ex_reg_wr_en,
  input  logic        ex_br_taken,
  output logic        freeze,
  output logic        br_taken,
  output logic        bubble,
  output logic        lmsm_valid,
  output logic [2:0]  lmsm_reg,
  output logic [15:0] lmsm_offset
);
  logic        state, flush_hold;
  logic [7:0]  rem_mask;
  logic [15:0] count;
  logic [2:0]  m_idx, r_idx;
  logic        m_none, m_single, r_none, r_single;
  logic        hz, is_lmsm, idle, start, multi;
  wire  [3:0]  ex_op = ex_ir[OPC_LSB+:4];
  wire  [3:0]  rr_op = ir_rr[OPC_LSB+:4];
  wire  [2:0]  ex_ra = ex_ir[RA_LSB+:3];
  wire  [7:0]  m = ir_rr[7:0];
  lowest_set_bit u_m (.mask(m), .idx(m_idx), .none(m_none), .single(m_single));
  lowest_set_bit u_r (.mask(rem_mask), .idx(r_idx), .none(r_none), .single(r_single));
  always_comb begin
    br_taken = ex_br_taken | flush_hold;
    hz = (ex_op == OP_LW) & ex_reg_wr_en & (ex_ra == ir_rr[RA_LSB+:3] | ex_ra == ir_rr[RB_LSB+:3]);
    is_lmsm = rr_op == OP_LM | rr_op == OP_SM;
    idle = ~br_taken & state == IDLE;
    multi = ~br_taken & state == MULTI & ~r_none;
    start = idle & ~hz & is_lmsm & ~m_none;
    bubble = idle & hz;
    lmsm_valid = start | multi;
    lmsm_reg = multi ? r_idx : start ? m_idx : 3'd0;
    lmsm_offset = multi ? count * 16'(ADDR_STEP) : 16'd0;
    freeze = multi ? ~r_single : start ? ~m_single : bubble;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      flush_hold <= 1'b0;
      rem_mask <= '0;
      count <= '0;
    end else begin
      flush_hold <= ex_br_taken;
      if (br_taken) begin
        state <= IDLE;
        rem_mask <= '0;
        count <= '0;
      end else if (multi) begin
        rem_mask <= rem_mask & (rem_mask - 8'd1);
        count <= count + 16'd1;
        state <= r_single ? IDLE : MULTI;
      end else if (start & ~m_single) begin
        rem_mask <= m & (m - 8'd1);
        count <= 16'd1;
        state <= MULTI;
      end
    end
  end
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb_hazard_flush_ctrl: directed test-plan sequences plus random traffic against a queue-based model.
module tb_hazard_flush_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] ir_rr = '0, ex_ir = '0;
  logic ex_reg_wr_en = 1'b0, ex_br_taken = 1'b0;
  logic freeze, br_taken, bubble, lmsm_valid;
  logic [2:0] lmsm_reg;
  logic [15:0] lmsm_offset;
  int total = 0, bad = 0;
  int pending[$];
  int k = 0;
  bit fh = 0;
  hazard_flush_ctrl dut (.clk(clk), .rst(rst), .ir_rr(ir_rr), .ex_ir(ex_ir),
    .ex_reg_wr_en(ex_reg_wr_en), .ex_br_taken(ex_br_taken), .freeze(freeze),
    .br_taken(br_taken), .bubble(bubble), .lmsm_valid(lmsm_valid),
    .lmsm_reg(lmsm_reg), .lmsm_offset(lmsm_offset));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [15:0] ins(input logic [3:0] op, input int ra, input int rb, input logic [7:0] lst);
    logic [15:0] r;
    r = {op, 3'(ra), 3'(rb), 6'd0};
    if (op == 4'b0110 || op == 4'b0111) r[7:0] = lst;
    return r;
  endfunction
  task automatic cycle(input logic [15:0] ir, input logic [15:0] ex, input logic wr, input logic bt, input logic r);
    bit e_bt, e_fr, e_bb, e_v, hz;
    int e_reg, e_off;
    int lst[$];
    @(negedge clk);
    ir_rr = ir; ex_ir = ex; ex_reg_wr_en = wr; ex_br_taken = bt; rst = r;
    #2;
    e_bt = bt | fh; e_fr = 0; e_bb = 0; e_v = 0; e_reg = 0; e_off = 0;
    hz = ex[15:12] == 4'b0100 && wr && (ex[11:9] == ir[11:9] || ex[11:9] == ir[8:6]);
    if (e_bt) pending.delete();
    else if (pending.size() > 0) begin
      e_v = 1; e_reg = pending.pop_front(); e_off = (k * 2) % 65536;
      e_fr = pending.size() > 0; k++;
    end else if (hz) begin
      e_fr = 1; e_bb = 1;
    end else if ((ir[15:12] == 4'b0110 || ir[15:12] == 4'b0111) && ir[7:0] != 0) begin
      for (int i = 0; i < 8; i++) if (ir[i]) lst.push_back(i);
      e_v = 1; e_reg = lst.pop_front(); e_off = 0; e_fr = lst.size() > 0;
      pending = lst; k = 1;
    end
    chk("br_taken", br_taken, e_bt);
    chk("freeze", freeze, e_fr);
    chk("bubble", bubble, e_bb);
    chk("lmsm_valid", lmsm_valid, e_v);
    chk("lmsm_reg", lmsm_reg, e_reg);
    chk("lmsm_offset", lmsm_offset, e_off);
    fh = bt;
    if (r) begin
      pending.delete(); fh = 0; k = 0;
    end
  endtask
  localparam logic [15:0] NOP = 16'h0000;
  logic [15:0] lw3, add3, lm_a4, lm_01, lm_00, lm_ff, sm_ff;
  initial begin
    lw3 = ins(4'b0100, 3, 0, 0);
    add3 = ins(4'b0000, 1, 3, 0);
    lm_a4 = ins(4'b0110, 0, 0, 8'hA4);
    lm_01 = ins(4'b0110, 0, 0, 8'h01);
    lm_00 = ins(4'b0110, 0, 0, 8'h00);
    lm_ff = ins(4'b0110, 0, 0, 8'hFF);
    sm_ff = ins(4'b0111, 0, 0, 8'hFF);
    repeat (2) @(posedge clk);
    cycle(NOP, NOP, 0, 0, 0);
    chk("reset_freeze", freeze, 0);
    cycle(add3, lw3, 1, 0, 0);
    chk("lu_freeze", freeze, 1); chk("lu_bubble", bubble, 1);
    cycle(add3, NOP, 0, 0, 0);
    chk("lu_release", freeze, 0);
    cycle(add3, lw3, 1, 1, 0);
    chk("br1", br_taken, 1); chk("br1_freeze", freeze, 0);
    cycle(add3, lw3, 1, 0, 0);
    chk("br2", br_taken, 1); chk("br2_freeze", freeze, 0);
    cycle(NOP, NOP, 0, 0, 0);
    chk("br_end", br_taken, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(lm_a4, NOP, 0, 0, 0);
      chk("a4_reg", lmsm_reg, i == 0 ? 2 : i == 1 ? 5 : 7);
      chk("a4_off", lmsm_offset, 2 * i);
      chk("a4_freeze", freeze, i < 2);
    end
    cycle(NOP, NOP, 0, 0, 0);
    chk("a4_done", lmsm_valid, 0);
    cycle(lm_01, NOP, 0, 0, 0);
    chk("m01_valid", lmsm_valid, 1); chk("m01_freeze", freeze, 0);
    cycle(lm_00, NOP, 0, 0, 0);
    chk("m00_valid", lmsm_valid, 0); chk("m00_freeze", freeze, 0);
    cycle(lm_ff, NOP, 0, 0, 0);
    cycle(lm_ff, NOP, 0, 0, 0);
    cycle(lm_ff, NOP, 0, 0, 1);
    chk("rst_mid_off", lmsm_offset, 4);
    cycle(NOP, NOP, 0, 0, 0);
    chk("post_rst_valid", lmsm_valid, 0); chk("post_rst_freeze", freeze, 0);
    cycle(lm_ff, NOP, 0, 0, 0);
    chk("restart_valid", lmsm_valid, 1); chk("restart_off", lmsm_offset, 0);
    cycle(NOP, NOP, 0, 0, 1);
    cycle(sm_ff, NOP, 0, 0, 0);
    cycle(sm_ff, NOP, 0, 1, 0);
    chk("fl_valid", lmsm_valid, 0); chk("fl_freeze", freeze, 0);
    cycle(NOP, NOP, 0, 0, 0);
    cycle(sm_ff, NOP, 0, 0, 0);
    chk("fl_restart_off", lmsm_offset, 0);
    for (int n = 0; n < 800; n++) begin
      logic [15:0] ir, ex;
      logic [3:0] op;
      int sel;
      sel = $urandom_range(0, 3);
      op = sel == 0 ? 4'b0110 : sel == 1 ? 4'b0111 : sel == 2 ? 4'b0100 : 4'($urandom_range(0, 15));
      ir = 16'($urandom);
      ir[15:12] = op;
      if ($urandom_range(0, 3) == 0) ir[7:0] = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ir[7:0] = 8'h00;
      ex = 16'($urandom);
      if ($urandom_range(0, 1) == 0) ex[15:12] = 4'b0100;
      cycle(ir, ex, 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
